physic_block_control_param: RTL and testbench

Parametrised successor of the SD physical-layer command controller. It sequences one command transaction per upstream strobe: load, serialise, then wait for the response through the parallel-to-serial and serial-to-parallel wrappers. It adds an internal response timeout counter, automatic retry with wrapper reset, no-response command mode and a configurable response width. It sits between the SD command-layer control and the PTS/STP wrappers and pad logic, in the SD clock domain.

---
 rtl/physic_block_control_param_pkg.sv | 39 +++
 rtl/physic_timeout_counter.sv | 45 ++++
 rtl/physic_block_control_param.sv | 167 ++++++++++++++++
 tb/tb_physic_block_control_param.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/physic_block_control_param_pkg.sv
// -----------------------------------------------------------------------------
// physic_block_control_param_pkg
//
// Shared definitions for the SD physical-layer command controller and the
// PTS/STP wrappers that sit next to it:
//   - default response width, response timeout and retry budget
//   - FSM state encoding of the command controller
//   - width helpers for the retry and timeout counters
// -----------------------------------------------------------------------------
package physic_block_control_param_pkg;

  // Defaults shared with the PTS/STP wrappers.
  localparam int DEFAULT_RESP_WIDTH     = 38;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_MAX_RETRIES    = 2;

  // Command controller states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_RETRY     = 3'd4,
    ST_DONE      = 3'd5
  } physicState_t;

  // Retry counter width. With retries disabled the counter still needs one
  // bit so that the port never collapses to zero width.
  function automatic int retryCountWidth(input int maxRetries);
    return (maxRetries > 0) ? $clog2(maxRetries + 1) : 1;
  endfunction

  // Timeout counter width. TIMEOUT_CYCLES is at least 2, so this is >= 1;
  // the guard only protects against a misconfigured instance.
  function automatic int timeoutCountWidth(input int timeoutCycles);
    return (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
  endfunction

endpackage

// File: rtl/physic_timeout_counter.sv
// -----------------------------------------------------------------------------
// physic_timeout_counter
//
// Response timeout counter for the command controller. Counts enabled cycles
// from zero and saturates at TIMEOUT_CYCLES-1, where it raises its terminal
// flag. It never wraps, so a stalled controller keeps seeing the terminal
// flag instead of a fresh count.
//
// Ports:
//   iClock_SD  in   SD clock, rising-edge
//   iReset     in   asynchronous active-high reset (count -> 0)
//   iClear     in   synchronous clear (count -> 0), wins over iEnable
//   iEnable    in   advance count by one this cycle
//   oTerminal  out  count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module physic_timeout_counter
  import physic_block_control_param_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic iClock_SD,
  input  logic iReset,
  input  logic iClear,
  input  logic iEnable,
  output logic oTerminal
);

  localparam int CNT_W = timeoutCountWidth(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TERMINAL_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] countReg;

  always_ff @(posedge iClock_SD or posedge iReset) begin
    if (iReset) begin
      countReg <= '0;
    end else if (iClear) begin
      countReg <= '0;
    end else if (iEnable && (countReg != TERMINAL_VALUE)) begin
      countReg <= countReg + 1'b1;
    end
  end

  assign oTerminal = (countReg == TERMINAL_VALUE);

endmodule

// File: rtl/physic_block_control_param.sv
// -----------------------------------------------------------------------------
// physic_block_control_param
//
// SD physical-layer command controller. For each upstream strobe it loads the
// command into the PTS wrapper, lets it shift out, then waits for the STP
// wrapper to deliver the response. A missing start bit or a response timeout
// counts as a failed attempt; failed attempts are retried (with a one-cycle
// wrapper reset) up to MAX_RETRIES times before the command is reported as
// timed out. Commands flagged as having no response finish right after the
// transmission.
//
// Parameters:
//   RESP_WIDTH      response payload width
//   TIMEOUT_CYCLES  WAIT_RESP cycles per attempt (>= 2)
//   MAX_RETRIES     extra attempts after the first failure (0 = no retry)
//
// Ports:
//   iClock_SD               in   SD clock
//   iReset                  in   asynchronous active-high reset
//   iStrobe_in              in   upstream request (4-phase with oAck_out)
//   iNo_resp_expected       in   command has no response (sampled with strobe)
//   iTransmission_complete  in   PTS wrapper finished shifting
//   iReception_complete     in   STP wrapper holds a full response
//   iNo_response            in   pad logic saw no start bit
//   iIdle_in                in   abort current transaction
//   iPad_response           in   parallel response from STP wrapper
//   oReset_wrapper          out  one-cycle wrapper reset before a retry
//   oLoad_send              out  load command into PTS wrapper
//   oPad_enable             out  host drives CMD pad
//   oEnable_PTS             out  PTS wrapper shifting
//   oEnable_STP             out  STP wrapper capturing
//   oResponse               out  last captured response
//   oCommand_timeout        out  final attempt failed
//   oRetry_count            out  retries used in current/last transaction
//   oAck_out                out  transaction finished
// -----------------------------------------------------------------------------
module physic_block_control_param
  import physic_block_control_param_pkg::*;
#(
  parameter int RESP_WIDTH     = DEFAULT_RESP_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = DEFAULT_MAX_RETRIES
) (
  input  logic                                   iClock_SD,
  input  logic                                   iReset,
  input  logic                                   iStrobe_in,
  input  logic                                   iNo_resp_expected,
  input  logic                                   iTransmission_complete,
  input  logic                                   iReception_complete,
  input  logic                                   iNo_response,
  input  logic                                   iIdle_in,
  input  logic [RESP_WIDTH-1:0]                  iPad_response,
  output logic                                   oReset_wrapper,
  output logic                                   oLoad_send,
  output logic                                   oPad_enable,
  output logic                                   oEnable_PTS,
  output logic                                   oEnable_STP,
  output logic [RESP_WIDTH-1:0]                  oResponse,
  output logic                                   oCommand_timeout,
  output logic [retryCountWidth(MAX_RETRIES)-1:0] oRetry_count,
  output logic                                   oAck_out
);

  physicState_t stateReg;
  logic         noRespReg;   // command of the current transaction has no response
  logic         timeoutHit;  // last WAIT_RESP cycle of this attempt
  logic         retryAvail;  // another attempt is still allowed
  logic         attemptFailed;

  // The counter is held at zero outside WAIT_RESP, so every attempt starts
  // from a clean count without an explicit clear pulse on entry.
  physic_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) uTimeoutCounter (
    .iClock_SD (iClock_SD),
    .iReset    (iReset),
    .iClear    (stateReg != ST_WAIT_RESP),
    .iEnable   (stateReg == ST_WAIT_RESP),
    .oTerminal (timeoutHit)
  );

  assign retryAvail    = (int'(oRetry_count) < MAX_RETRIES);
  assign attemptFailed = iNo_response || timeoutHit;

  always_ff @(posedge iClock_SD or posedge iReset) begin
    if (iReset) begin
      stateReg         <= ST_IDLE;
      noRespReg        <= 1'b0;
      oResponse        <= '0;
      oCommand_timeout <= 1'b0;
      oRetry_count     <= '0;
    end else begin
      case (stateReg)
        ST_IDLE: begin
          if (iStrobe_in) begin
            stateReg         <= ST_LOAD;
            noRespReg        <= iNo_resp_expected;
            oRetry_count     <= '0;
            oCommand_timeout <= 1'b0;
          end
        end

        // Holding strobe high after the ack is not a new request: the
        // handshake must return to zero before IDLE is re-entered.
        ST_DONE: begin
          if (!iStrobe_in) begin
            stateReg <= ST_IDLE;
          end
        end

        default: begin
          // Abort beats every completion event; nothing is captured and the
          // timeout flag keeps whatever value it already had.
          if (iIdle_in) begin
            stateReg <= ST_IDLE;
          end else begin
            case (stateReg)
              ST_LOAD: begin
                stateReg <= ST_SEND;
              end

              ST_SEND: begin
                if (iTransmission_complete) begin
                  stateReg <= noRespReg ? ST_DONE : ST_WAIT_RESP;
                end
              end

              // A response arriving on the same cycle as a no-response flag
              // or the terminal timeout cycle is still accepted.
              ST_WAIT_RESP: begin
                if (iReception_complete) begin
                  oResponse <= iPad_response;
                  stateReg  <= ST_DONE;
                end else if (attemptFailed) begin
                  if (retryAvail) begin
                    oRetry_count <= oRetry_count + 1'b1;
                    stateReg     <= ST_RETRY;
                  end else begin
                    oCommand_timeout <= 1'b1;
                    stateReg         <= ST_DONE;
                  end
                end
              end

              ST_RETRY: begin
                stateReg <= ST_LOAD;
              end

              default: begin
                stateReg <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  // Moore decode of the strobes from the registered state.
  assign oLoad_send     = (stateReg == ST_LOAD);
  assign oPad_enable    = (stateReg == ST_LOAD) || (stateReg == ST_SEND);
  assign oEnable_PTS    = (stateReg == ST_SEND);
  assign oEnable_STP    = (stateReg == ST_WAIT_RESP);
  assign oReset_wrapper = (stateReg == ST_RETRY);
  assign oAck_out       = (stateReg == ST_DONE);

endmodule

// File: tb/tb_physic_block_control_param.sv
module tb_physic_block_control_param;
  import physic_block_control_param_pkg::*;

  localparam int RESP_W = 38;
  localparam int TO     = 16;
  localparam int MR     = 2;
  localparam int RC_W   = retryCountWidth(MR);

  // Attempt outcome kinds used by the stimulus and the model.
  localparam int K_NONE   = 0;  // nothing happens: attempt times out
  localparam int K_RX     = 1;  // reception at the given WAIT_RESP cycle
  localparam int K_NORESP = 2;  // no-response flag at the given cycle
  localparam int K_BOTH   = 3;  // reception and no-response together

  logic              clk = 1'b0;
  logic              iReset;
  logic              iStrobe_in;
  logic              iNo_resp_expected;
  logic              iTransmission_complete;
  logic              iReception_complete;
  logic              iNo_response;
  logic              iIdle_in;
  logic [RESP_W-1:0] iPad_response;
  logic              oReset_wrapper;
  logic              oLoad_send;
  logic              oPad_enable;
  logic              oEnable_PTS;
  logic              oEnable_STP;
  logic [RESP_W-1:0] oResponse;
  logic              oCommand_timeout;
  logic [RC_W-1:0]   oRetry_count;
  logic              oAck_out;

  physic_block_control_param #(
    .RESP_WIDTH     (RESP_W),
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRIES    (MR)
  ) dut (
    .iClock_SD              (clk),
    .iReset                 (iReset),
    .iStrobe_in             (iStrobe_in),
    .iNo_resp_expected      (iNo_resp_expected),
    .iTransmission_complete (iTransmission_complete),
    .iReception_complete    (iReception_complete),
    .iNo_response           (iNo_response),
    .iIdle_in               (iIdle_in),
    .iPad_response          (iPad_response),
    .oReset_wrapper         (oReset_wrapper),
    .oLoad_send             (oLoad_send),
    .oPad_enable            (oPad_enable),
    .oEnable_PTS            (oEnable_PTS),
    .oEnable_STP            (oEnable_STP),
    .oResponse              (oResponse),
    .oCommand_timeout       (oCommand_timeout),
    .oRetry_count           (oRetry_count),
    .oAck_out               (oAck_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int txnNum = 0;
  logic [RESP_W-1:0] modelResp = '0;  // model of the last captured response

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RESP_W-1:0] randResp();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[RESP_W-1:0];
  endfunction

  function automatic logic [5:0] strobes();
    return {oReset_wrapper, oLoad_send, oPad_enable, oEnable_PTS, oEnable_STP, oAck_out};
  endfunction

  // Reference model: walks the attempts in order. A reception ends the
  // transaction successfully; anything else is a failure that costs one
  // retry until the budget is used up.
  function automatic void predict(input bit nr, input int kinds[3], input int idxs[3],
                                  output int retries, output bit tmo,
                                  output bit captured, output int stpCycles);
    retries = 0; tmo = 1'b0; captured = 1'b0; stpCycles = 0;
    if (!nr) begin
      for (int a = 0; a <= MR; a++) begin
        if (kinds[a] == K_RX || kinds[a] == K_BOTH) begin
          stpCycles += idxs[a] + 1;
          captured = 1'b1;
          break;
        end
        stpCycles += (kinds[a] == K_NORESP) ? idxs[a] + 1 : TO;
        if (retries < MR) begin
          retries++;
        end else begin
          tmo = 1'b1;
          break;
        end
      end
    end
  endfunction

  task automatic clearEvents();
    iTransmission_complete = 1'b0;
    iReception_complete    = 1'b0;
    iNo_response           = 1'b0;
    iIdle_in               = 1'b0;
  endtask

  task automatic runTxn(input bit nr, input int sendDelay,
                        input int k0, input int i0, input int k1, input int i1,
                        input int k2, input int i2, input logic [RESP_W-1:0] payload);
    int kinds[3];
    int idxs[3];
    int expRetries, expStp;
    bit expTmo, expCap;
    logic [RESP_W-1:0] expResp;
    int ptsRun, waitIdx, attempt, stpCnt, rwCnt, loadCnt;
    bit done;
    kinds[0] = k0; kinds[1] = k1; kinds[2] = k2;
    idxs[0] = i0;  idxs[1] = i1;  idxs[2] = i2;
    predict(nr, kinds, idxs, expRetries, expTmo, expCap, expStp);
    expResp = expCap ? payload : modelResp;
    ptsRun = 0; waitIdx = 0; attempt = 0; stpCnt = 0; rwCnt = 0; loadCnt = 0; done = 1'b0;

    @(negedge clk);
    iStrobe_in = 1'b1;
    iNo_resp_expected = nr;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      @(negedge clk);
      iNo_resp_expected = 1'b0;
      clearEvents();
      iPad_response = randResp();
      if (cyc == 0) checkVal("load_at_n1", oLoad_send, 1);
      if (cyc == 1) checkVal("pts_at_n2", oEnable_PTS, 1);
      if (oLoad_send) begin
        loadCnt++;
        ptsRun = 0;
      end
      if (oReset_wrapper) begin
        rwCnt++;
        attempt++;
        waitIdx = 0;
      end
      if (oEnable_PTS) begin
        ptsRun++;
        if (ptsRun == sendDelay) iTransmission_complete = 1'b1;
      end
      if (oEnable_STP) begin
        stpCnt++;
        if (attempt < 3 && waitIdx == idxs[attempt]) begin
          case (kinds[attempt])
            K_RX:     begin iReception_complete = 1'b1; iPad_response = payload; end
            K_NORESP: iNo_response = 1'b1;
            K_BOTH:   begin iReception_complete = 1'b1; iNo_response = 1'b1; iPad_response = payload; end
            default:  ;
          endcase
        end
        waitIdx++;
      end
      if (oAck_out) begin
        done = 1'b1;
        checkVal("response", oResponse, expResp);
        checkVal("retry_count", oRetry_count, expRetries);
        checkVal("cmd_timeout", oCommand_timeout, expTmo);
      end
    end
    checkVal("ack_seen", done, 1);
    checkVal("stp_cycles", stpCnt, expStp);
    checkVal("wrapper_resets", rwCnt, expRetries);
    checkVal("loads", loadCnt, expRetries + 1);
    if (done) begin
      @(negedge clk);
      checkVal("ack_hold", oAck_out, 1);
      iStrobe_in = 1'b0;
      @(negedge clk);
      checkVal("ack_drop", oAck_out, 0);
      checkVal("idle_quiet", strobes(), 0);
    end else begin
      // Recover a stuck DUT so later transactions still run.
      iStrobe_in = 1'b0;
      iIdle_in = 1'b1;
      @(negedge clk);
      iIdle_in = 1'b0;
    end
    modelResp = expResp;
    txnNum++;
    $display("txn %0d nr=%0d send=%0d kinds=%0d/%0d/%0d idx=%0d/%0d/%0d resp=%0h retries=%0d tmo=%0d stp=%0d",
             txnNum, nr, sendDelay, k0, k1, k2, i0, i1, i2, expResp, expRetries, expTmo, expStp);
  endtask

  task automatic runAbort();
    @(negedge clk);
    iStrobe_in = 1'b1;
    iNo_resp_expected = 1'b0;
    for (int c = 0; c < 50 && !oEnable_PTS; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkVal("abort_in_send", oEnable_PTS, 1);
    iIdle_in = 1'b1;
    iStrobe_in = 1'b0;
    @(negedge clk);
    iIdle_in = 1'b0;
    checkVal("abort_quiet", strobes(), 0);
    repeat (3) @(negedge clk);
    checkVal("abort_no_ack", oAck_out, 0);
    checkVal("abort_resp_kept", oResponse, modelResp);
    checkVal("abort_tmo", oCommand_timeout, 0);
    txnNum++;
    $display("txn %0d abort during SEND", txnNum);
  endtask

  task automatic runResetMidWait();
    bit rwSeen, reached;
    rwSeen = 1'b0; reached = 1'b0;
    @(negedge clk);
    iStrobe_in = 1'b1;
    iNo_resp_expected = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      @(negedge clk);
      clearEvents();
      iTransmission_complete = oEnable_PTS;
      if (oReset_wrapper) rwSeen = 1'b1;
      if (oEnable_STP) begin
        if (rwSeen) reached = 1'b1;
        else iNo_response = 1'b1;
      end
    end
    clearEvents();
    checkVal("reached_wait", reached, 1);
    checkVal("retry_before_rst", oRetry_count, 1);
    #2;
    iReset = 1'b1;
    iStrobe_in = 1'b0;
    #1;
    checkVal("rst_strobes", strobes(), 0);
    checkVal("rst_resp", oResponse, 0);
    checkVal("rst_retry", oRetry_count, 0);
    checkVal("rst_tmo", oCommand_timeout, 0);
    @(negedge clk);
    iReset = 1'b0;
    modelResp = '0;
    repeat (2) @(negedge clk);
    checkVal("post_rst_no_ack", oAck_out, 0);
    txnNum++;
    $display("txn %0d reset during WAIT_RESP", txnNum);
  endtask

  initial begin
    iReset = 1'b1;
    iStrobe_in = 1'b0;
    iNo_resp_expected = 1'b0;
    iPad_response = '0;
    clearEvents();
    #3;
    checkVal("reset_strobes", strobes(), 0);
    checkVal("reset_resp", oResponse, 0);
    checkVal("reset_retry", oRetry_count, 0);
    checkVal("reset_tmo", oCommand_timeout, 0);
    repeat (2) @(negedge clk);
    iReset = 1'b0;

    // Directed cases.
    runTxn(1'b0, 10, K_RX, 4, K_NONE, 0, K_NONE, 0, 38'd7);
    runTxn(1'b1, 5, K_RX, 0, K_NONE, 0, K_NONE, 0, randResp());
    runTxn(1'b0, 3, K_NONE, 0, K_NONE, 0, K_NONE, 0, randResp());
    runTxn(1'b0, 4, K_NORESP, 3, K_RX, 6, K_NONE, 0, randResp());
    runTxn(1'b0, 2, K_BOTH, 2, K_NONE, 0, K_NONE, 0, randResp());
    runTxn(1'b0, 1, K_RX, TO - 1, K_NONE, 0, K_NONE, 0, randResp());
    runTxn(1'b0, 6, K_NONE, 0, K_NORESP, 0, K_RX, TO - 1, randResp());

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      runTxn($urandom_range(0, 5) == 0, $urandom_range(1, 12),
             $urandom_range(0, 3), $urandom_range(0, TO - 1),
             $urandom_range(0, 3), $urandom_range(0, TO - 1),
             $urandom_range(0, 3), $urandom_range(0, TO - 1),
             randResp());
    end

    runAbort();
    runResetMidWait();
    runTxn(1'b0, 2, K_RX, 1, K_NONE, 0, K_NONE, 0, randResp());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=stuck want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
